// File: rtl/pipe_pkg.sv
// Types and constants shared by the MIPS pipeline stages.
// The decode stage and the hazard unit reuse NOP_INSTR and the fetch state encoding.
package pipe_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // All-zero word decodes as sll $0,$0,0, which is the architectural NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble wins over a load; with neither asserted it holds.
// The hazard unit's flush path drives the same bubble control.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc4
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q,   pc4_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = DATA_W'(NOP_INSTR);
      pc4_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc4_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= DATA_W'(NOP_INSTR);
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and fills IF/ID.
// Handles stall, branch/jump redirect and an end-of-program halt at PC_LIMIT.
module if_fetch_stage
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 8'h44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_read,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              ifid_load, ifid_bubble;
  logic              unused_redirect_lsbs;

  // Targets are word aligned; the byte-offset bits of redirect_pc are dropped.
  assign redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_inc               = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      // Memory output is stale until memread has been high, so WAIT never captures.
      ST_WAIT: state_d = ST_FETCH;
      ST_FETCH, ST_HALT: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = (redirect_tgt == PC_LIMIT) ? ST_HALT : ST_FETCH;
        end else if (state_q == ST_FETCH && !stall) begin
          pc_d    = pc_inc;
          state_d = (pc_inc == PC_LIMIT) ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    imem_read   = 1'b0;
    halted      = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      ST_WAIT: ;
      ST_FETCH: begin
        imem_read   = 1'b1;
        ifid_bubble = redirect;
        ifid_load   = !redirect && !stall;
      end
      ST_HALT: begin
        halted      = 1'b1;
        ifid_bubble = redirect || !stall;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (imem_data),
    .pc4_in   (pc_inc),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: each stimulus cycle queues the expected outputs
// after the next edge; a negedge monitor pops and compares them.
module tb_if_fetch_stage;

  typedef struct {
    string       tag;
    logic        rd;
    logic [7:0]  addr;
    logic        v;
    logic [31:0] instr;
    logic [7:0]  pc4;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_read;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc4;
  logic        halted;

  logic [31:0] mem [64];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  if_fetch_stage #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'h00),
    .PC_LIMIT (8'h44)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_read   (imem_read),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory returns garbage while not read, so a capture outside FETCH shows up.
  assign imem_data = imem_read ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic rd, input logic [7:0] addr,
                              input logic v, input logic [31:0] instr,
                              input logic [7:0] pc4, input logic h);
    exp_t e;
    e.tag = tag; e.rd = rd; e.addr = addr; e.v = v; e.instr = instr; e.pc4 = pc4; e.h = h;
    return e;
  endfunction

  // Drives one cycle of inputs at negedge+1 and queues what must be seen after the edge.
  task automatic step(input logic s, input logic r, input logic [7:0] rpc, input exp_t e);
    stall = s; redirect = r; redirect_pc = rpc;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".imem_read"},  32'(imem_read),  32'h0);
    check({tag, ".imem_addr"},  32'(imem_addr),  32'h00);
    check({tag, ".ifid_valid"}, 32'(ifid_valid), 32'h0);
    check({tag, ".ifid_instr"}, ifid_instr,      32'h0);
    check({tag, ".ifid_pc4"},   32'(ifid_pc4),   32'h00);
    check({tag, ".halted"},     32'(halted),     32'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".imem_read"},  32'(imem_read),  32'(mon_e.rd));
      check({mon_e.tag, ".imem_addr"},  32'(imem_addr),  32'(mon_e.addr));
      check({mon_e.tag, ".ifid_valid"}, 32'(ifid_valid), 32'(mon_e.v));
      check({mon_e.tag, ".ifid_instr"}, ifid_instr,      mon_e.instr);
      check({mon_e.tag, ".ifid_pc4"},   32'(ifid_pc4),   32'(mon_e.pc4));
      check({mon_e.tag, ".halted"},     32'(halted),     32'(mon_e.h));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nxt;
    for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
    mem[0]  = 32'h20010001; mem[1]  = 32'h20020002; mem[2]  = 32'h20030003;
    mem[3]  = 32'h20040004; mem[4]  = 32'h00221820; mem[5]  = 32'h00642022;
    mem[6]  = 32'h00832824; mem[7]  = 32'h00a43025; mem[8]  = 32'h00c5382a;
    mem[9]  = 32'hac070010; mem[10] = 32'h00230820; mem[11] = 32'h8c080010;
    mem[12] = 32'h10220002; mem[13] = 32'h20090009; mem[14] = 32'h200a000a;
    mem[15] = 32'h200b000b; mem[16] = 32'h0800000A; mem[63] = 32'h12345678;

    // 1: reset, WAIT cycle, then first fetches.
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("in_reset");
    rst_n = 1'b1;
    #1;
    check_reset_values("wait_state");
    step(0, 0, 8'h00, mk("first_fetch", 1, 8'h00, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("cap_00",      1, 8'h04, 1, 32'h20010001, 8'h04, 0));
    step(0, 0, 8'h00, mk("cap_04",      1, 8'h08, 1, 32'h20020002, 8'h08, 0));

    // 2: stall three cycles at pc 0x08.
    repeat (3) step(1, 0, 8'h00, mk("stall_08", 1, 8'h08, 1, 32'h20020002, 8'h08, 0));
    step(0, 0, 8'h00, mk("cap_08", 1, 8'h0C, 1, 32'h20030003, 8'h0C, 0));

    // 3: redirect with misaligned target beats a simultaneous stall.
    step(1, 1, 8'h2B, mk("redir_2b", 1, 8'h28, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("cap_28",   1, 8'h2C, 1, 32'h00230820, 8'h2C, 0));

    // 4: free-run to the end of program, then HALT behaviour.
    for (int a = 8'h2C; a <= 8'h40; a += 4) begin
      nxt = 8'(a + 4);
      step(0, 0, 8'h00, mk("run", nxt != 8'h44, nxt, 1, mem[a >> 2], nxt, nxt == 8'h44));
    end
    step(1, 0, 8'h00, mk("halt_stall", 0, 8'h44, 1, 32'h0800000A, 8'h44, 1));
    repeat (2) step(0, 0, 8'h00, mk("halt_bubble", 0, 8'h44, 0, 32'h0, 8'h00, 1));
    step(0, 1, 8'h28, mk("halt_redir", 1, 8'h28, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("resume_28",  1, 8'h2C, 1, 32'h00230820, 8'h2C, 0));

    // 5: reach pc 0x1C with valid IF/ID, then asynchronous reset mid-cycle.
    step(0, 1, 8'h14, mk("redir_14", 1, 8'h14, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("cap_14",   1, 8'h18, 1, 32'h00642022, 8'h18, 0));
    step(0, 0, 8'h00, mk("cap_18",   1, 8'h1C, 1, 32'h00832824, 8'h1C, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_reset_values("rewait");
    step(0, 0, 8'h00, mk("refetch", 1, 8'h00, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("recap_00", 1, 8'h04, 1, 32'h20010001, 8'h04, 0));

    // 6: redirect straight onto PC_LIMIT halts immediately.
    step(0, 1, 8'h44, mk("redir_44", 0, 8'h44, 0, 32'h0, 8'h00, 1));
    step(0, 0, 8'h00, mk("held_44",  0, 8'h44, 0, 32'h0, 8'h00, 1));

    // PC wraps modulo 256.
    step(0, 1, 8'hFE, mk("redir_fc", 1, 8'hFC, 0, 32'h0, 8'h00, 0));
    step(0, 0, 8'h00, mk("wrap_fc",  1, 8'h00, 1, 32'h12345678, 8'h00, 0));

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
